interval_meter_ctrl: RTL
========================

// Module: interval_meter_ctrl
// PURPOSE
//  Sequencer for one external WIDTH-bit start/stop/reset/load/count counter. Measures the
//  interval between a start-trigger edge and a stop-trigger edge in prescaled clk ticks.
//  Delivers the result over a valid/ready handshake to the host register block.
//  Sits between the probe trigger inputs and the shared counter.
// PARAMETERS
//  WIDTH     16  counter/result/timeout/offset width
//  PRE_W      8  prescaler width
// PORTS
//  clk           in   1      system clock; single clock domain
//  sysrst        in   1      synchronous, active-high reset
//  arm           in   1      pulse: begin a measurement (IDLE only)
//  abort         in   1      pulse: cancel; any state -> IDLE
//  repeat_mode   in   1      1: re-arm automatically after result is consumed
//  cfg_start_fall in  1      0: start on rising edge of trig_start, 1: on falling edge
//  cfg_stop_fall in   1      same selection for trig_stop
//  cfg_prescale  in   PRE_W  counter advances once every cfg_prescale+1 cycles
//  cfg_offset    in   WIDTH  value preloaded into the counter on arm
//  cfg_timeout   in   WIDTH  overflow threshold
//  trig_start    in   1      start trigger level (already synchronised)
//  trig_stop     in   1      stop trigger level (already synchronised)
//  cnt_start/cnt_stop/cnt_reset/cnt_load/cnt_count  out 1  counter controls
//  cnt_ivalue    out  WIDTH  counter load value (= cfg_offset)
//  cnt_value     in   WIDTH  counter current value
//  result        out  WIDTH  captured interval
//  result_ovf    out  1      result ended by timeout, not by a stop edge
//  result_valid  out  1      result/result_ovf are stable while high
//  result_ready  in   1      host accepts the result
//  busy          out  1      high in every state except IDLE
// BEHAVIOUR
//  - Edge detection: each trigger has a previous-level register, cleared by sysrst.
//    Rising edge = lvl & ~prev; falling edge = ~lvl & prev.
//  - States: IDLE, ARMED, RUN, CAPTURE, HOLD. Every cnt_* strobe is a 1-cycle combinational pulse.
//  - IDLE: arm -> cnt_load=1, go ARMED.
//  - ARMED: selected start edge -> cnt_start=1, clear the prescaler, go RUN.
//    A stop edge in the same cycle is ignored.
//  - RUN: the prescaler counts 0..cfg_prescale; at wrap it drives cnt_count=1 that cycle.
//    cfg_prescale=0 gives cnt_count every cycle. Start edges are ignored.
//    - Stop edge -> cnt_stop=1, ovf<=0, go CAPTURE.
//    - Else if cnt_value >= cfg_timeout -> cnt_stop=1, ovf<=1, go CAPTURE.
//    - A stop edge beats the timeout in the same cycle.
//  - CAPTURE (one cycle): result<=cnt_value (includes any count in the cnt_stop cycle),
//    result_ovf<=ovf, result_valid<=1, go HOLD.
//  - HOLD: result, result_ovf and result_valid are held until result_valid & result_ready.
//    On that handshake, result_valid<=0 and then:
//    - repeat_mode=1: cnt_load=1, go ARMED.
//    - repeat_mode=0: go IDLE.
//    arm is ignored in HOLD.
//  - abort (priority over all the above, any state except IDLE):
//    cnt_stop=1, cnt_reset=1, result_valid<=0, go IDLE.
//  - Latency: a stop edge at cycle T gives result_valid=1 at T+2. Earliest re-arm is the cycle after the handshake.
//  - No wrap handling: the counter wraps at 2^WIDTH. cfg_timeout <= max-1 guarantees overflow is detected first.
//  - cfg_* inputs are sampled live; the host changes them only in IDLE.
//  - sysrst: state IDLE; all cnt_* = 0; result=0; result_ovf=0; result_valid=0; busy=0;
//    prescaler=0; edge registers=0. A sysrst mid-measurement discards everything.
// TESTING
//  1 cfg_prescale=0, offset=0; arm, start rise @10, stop rise @35
//    -> result=25, ovf=0, result_valid @37.
//  2 cfg_prescale=3; start->stop distance 40 cycles -> result=10.
//  3 cfg_timeout=100, no stop edge -> result=100, ovf=1.
//    Variant: stop edge in the same cycle as the timeout -> ovf=0.
//  4 Hold result_ready=0 for 20 cycles, toggling the triggers -> result stable, no counter strobes.
//    Then with repeat_mode=1 -> cnt_load pulse and ARMED.
//  5 abort in RUN -> cnt_stop=cnt_reset=1, IDLE, result_valid stays 0.
//    sysrst in HOLD -> all outputs 0.
//  6 cfg_start_fall=1, start and stop edges in the same cycle in ARMED
//    -> enters RUN, stop ignored; next stop edge ends the measurement.

Source files
------------

// File: rtl/interval_meter_if.sv
// Counter control bus and result handshake shared by the interval meter
// sequencer (master) and the counter/host side (slave).
interface interval_meter_if #(
    parameter int WIDTH = 16
);
    logic             cnt_start;
    logic             cnt_stop;
    logic             cnt_reset;
    logic             cnt_load;
    logic             cnt_count;
    logic [WIDTH-1:0] cnt_ivalue;
    logic [WIDTH-1:0] cnt_value;
    logic [WIDTH-1:0] result;
    logic             result_ovf;
    logic             result_valid;
    logic             result_ready;

    modport master (
        output cnt_start, cnt_stop, cnt_reset, cnt_load, cnt_count,
        output cnt_ivalue,
        input  cnt_value,
        output result, result_ovf, result_valid,
        input  result_ready
    );

    modport slave (
        input  cnt_start, cnt_stop, cnt_reset, cnt_load, cnt_count,
        input  cnt_ivalue,
        output cnt_value,
        input  result, result_ovf, result_valid,
        output result_ready
    );
endinterface

// File: rtl/interval_meter_ctrl.sv
// Sequencer for an external start/stop/load/count counter: measures the
// start-edge to stop-edge interval in prescaled ticks, with timeout.
module interval_meter_ctrl #(
    parameter int WIDTH = 16,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             sysrst,
    input  logic             arm,
    input  logic             abort,
    input  logic             repeat_mode,
    input  logic             cfg_start_fall,
    input  logic             cfg_stop_fall,
    input  logic [PRE_W-1:0] cfg_prescale,
    input  logic [WIDTH-1:0] cfg_offset,
    input  logic [WIDTH-1:0] cfg_timeout,
    input  logic             trig_start,
    input  logic             trig_stop,
    interval_meter_if.master bus,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        RUN,
        CAPTURE,
        HOLD
    } state_t;

    state_t state, nxt;

    logic             prev_start, prev_stop;
    logic [PRE_W-1:0] presc;
    logic             ovf_q;
    logic [WIDTH-1:0] res_q;
    logic             rovf_q;
    logic             valid_q;

    logic start_edge, stop_edge, wrap, kill;
    logic start_go, run_end, to_go, ack;
    logic c_start, c_stop, c_reset, c_load, c_count;

    assign start_edge = cfg_start_fall ? (~trig_start & prev_start)
                                       : (trig_start & ~prev_start);
    assign stop_edge  = cfg_stop_fall  ? (~trig_stop & prev_stop)
                                       : (trig_stop & ~prev_stop);
    assign wrap = (presc == cfg_prescale);
    assign kill = abort && (state != IDLE);

    always_ff @(posedge clk) begin
        if (sysrst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt      = state;
        c_start  = 1'b0;
        c_stop   = 1'b0;
        c_reset  = 1'b0;
        c_load   = 1'b0;
        c_count  = 1'b0;
        start_go = 1'b0;
        run_end  = 1'b0;
        to_go    = 1'b0;
        ack      = 1'b0;
        if (kill) begin
            c_stop  = 1'b1;
            c_reset = 1'b1;
            nxt     = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arm) begin
                        c_load = 1'b1;
                        nxt    = ARMED;
                    end
                end
                ARMED: begin
                    if (start_edge) begin
                        c_start  = 1'b1;
                        start_go = 1'b1;
                        nxt      = RUN;
                    end
                end
                RUN: begin
                    c_count = wrap;
                    // a stop edge wins over a simultaneous timeout
                    if (stop_edge) begin
                        c_stop  = 1'b1;
                        run_end = 1'b1;
                        nxt     = CAPTURE;
                    end else if (bus.cnt_value >= cfg_timeout) begin
                        c_stop  = 1'b1;
                        run_end = 1'b1;
                        to_go   = 1'b1;
                        nxt     = CAPTURE;
                    end
                end
                CAPTURE: begin
                    nxt = HOLD;
                end
                HOLD: begin
                    if (bus.result_ready) begin
                        ack = 1'b1;
                        if (repeat_mode) begin
                            c_load = 1'b1;
                            nxt    = ARMED;
                        end else begin
                            nxt = IDLE;
                        end
                    end
                end
                default: begin
                    nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sysrst) begin
            prev_start <= 1'b0;
            prev_stop  <= 1'b0;
            presc      <= '0;
            ovf_q      <= 1'b0;
            res_q      <= '0;
            rovf_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            prev_start <= trig_start;
            prev_stop  <= trig_stop;
            if (start_go) begin
                presc <= '0;
            end else if (state == RUN) begin
                presc <= wrap ? '0 : presc + PRE_W'(1);
            end
            if (run_end) begin
                ovf_q <= to_go;
            end
            if (kill) begin
                valid_q <= 1'b0;
            end else if (state == CAPTURE) begin
                res_q   <= bus.cnt_value;
                rovf_q  <= ovf_q;
                valid_q <= 1'b1;
            end else if (ack) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.cnt_start    = c_start;
    assign bus.cnt_stop     = c_stop;
    assign bus.cnt_reset    = c_reset;
    assign bus.cnt_load     = c_load;
    assign bus.cnt_count    = c_count;
    assign bus.cnt_ivalue   = cfg_offset;
    assign bus.result       = res_q;
    assign bus.result_ovf   = rovf_q;
    assign bus.result_valid = valid_q;
    assign busy             = (state != IDLE);

endmodule
